// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit, one op in flight, registered writeback.
// Define MDU_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       rd_in,
    input  logic             kill,
    output logic             busy,
    output logic [4:0]       rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_we
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;

    logic [2:0]         f3_q;
    logic               na_q;
    logic               nb_q;
    logic               bz_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   opd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    logic               a_sgn;
    logic               b_sgn;
    logic               na_c;
    logic               nb_c;
    logic [WIDTH-1:0]   ma_c;
    logic [WIDTH-1:0]   mb_c;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     sh;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] acc_nxt;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (funct3)
            3'b001, 3'b100, 3'b110: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'b010: a_sgn = 1'b1;
            default: ;
        endcase
        na_c = a_sgn & op_a[WIDTH-1];
        nb_c = b_sgn & op_b[WIDTH-1];
        ma_c = na_c ? -op_a : op_a;
        mb_c = nb_c ? -op_b : op_b;
    end

    // Multiply keeps the multiplier in the low half and shifts the partial
    // product in from the top; divide keeps remainder:quotient in acc.
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
        sh      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_sub = WIDTH'(sh - {1'b0, opd_q});
        acc_nxt = acc_q;
        if (f3_q[2]) begin
            if (sh >= {1'b0, opd_q})
                acc_nxt = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_nxt = {sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_nxt = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    function automatic logic [WIDTH-1:0] pick(
        input logic [2:0]         f,
        input logic [2*WIDTH-1:0] r,
        input logic               sa,
        input logic               sb,
        input logic               bz,
        input logic [WIDTH-1:0]   a
    );
        logic [2*WIDTH-1:0] p;
        logic [WIDTH-1:0]   q;
        logic [WIDTH-1:0]   m;
        logic [WIDTH-1:0]   res;
        p = (sa ^ sb) ? -r : r;
        q = (sa ^ sb) ? -r[WIDTH-1:0] : r[WIDTH-1:0];
        m = sa ? -r[2*WIDTH-1:WIDTH] : r[2*WIDTH-1:WIDTH];
        unique case (f)
            3'b000:                 res = p[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: res = p[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         res = bz ? '1 : q;
            default:                res = bz ? a : m;
        endcase
        return res;
    endfunction

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, ma_c} * {{WIDTH{1'b0}}, mb_c};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd      <= '0;
            rd_data <= '0;
            rd_we   <= 1'b0;
            f3_q    <= '0;
            na_q    <= 1'b0;
            nb_q    <= 1'b0;
            bz_q    <= 1'b0;
            a_q     <= '0;
            opd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            rd_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid && !kill) begin
                        f3_q  <= funct3;
                        na_q  <= na_c;
                        nb_q  <= nb_c;
                        bz_q  <= (op_b == '0);
                        a_q   <= op_a;
                        opd_q <= mb_c;
                        acc_q <= {{WIDTH{1'b0}}, ma_c};
                        cnt_q <= '0;
                        rd    <= rd_in;
`ifdef MDU_FAST_MUL_EN
                        if (!funct3[2]) begin
                            rd_data <= pick(funct3, fast_prod, na_c, nb_c,
                                            1'b0, op_a);
                            rd_we   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            rd_data <= pick(f3_q, acc_nxt, na_q, nb_q,
                                            bz_q, a_q);
                            rd_we   <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
// Writeback latency expectations follow MDU_FAST_MUL_EN when it is defined.
module tb_mul_div_unit;

    localparam int DIV_LAT = 33;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        rd_we;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct3   (funct3),
        .op_a     (op_a),
        .op_b     (op_b),
        .rd_in    (rd_in),
        .kill     (kill),
        .busy     (busy),
        .rd       (rd),
        .rd_data  (rd_data),
        .rd_we    (rd_we)
    );

    always #5 clk = ~clk;

    // Called 1ns into a cycle; returns 1ns into the cycle after the accept edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r);
        in_valid = 1'b1;
        funct3   = f;
        op_a     = a;
        op_b     = b;
        rd_in    = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h1234_5678;
        rd_in    = 5'd31;
        funct3   = 3'b111;
    endtask

    // Stimulus helper only: lat is the cycle (1 = first after accept) of the
    // first rd_we, or -1 if none appears within the bound.
    task automatic wait_wb(output int lat, output logic [31:0] d,
                           output logic [4:0] r, output bit rdy_low,
                           output logic post_we, output logic post_rdy);
        lat      = -1;
        d        = 'x;
        r        = 'x;
        rdy_low  = 1'b1;
        post_we  = 1'bx;
        post_rdy = 1'bx;
        for (int j = 1; j <= 60; j++) begin
            if (in_ready !== 1'b0) rdy_low = 1'b0;
            if (rd_we === 1'b1) begin
                lat = j;
                d   = rd_data;
                r   = rd;
                @(posedge clk);
                #1;
                post_we  = rd_we;
                post_rdy = in_ready;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rd, rd_data, rd_we} !== 38'd0) begin
            bad++;
            $display("FAIL reset_wb: got rd=%0d data=%h we=%b want 0/0/0",
                     rd, rd_data, rd_we);
        end
        total++;
        if ({busy, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_hs: got busy=%b in_ready=%b want 0/1",
                     busy, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat;
        logic [31:0] d;
        logic [4:0] r;
        bit lo;
        logic pw, pr;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_wb(lat, d, r, lo, pw, pr);
        total++;
        if (lat !== MUL_LAT) begin
            bad++;
            $display("FAIL mul_lat: got %0d want %0d", lat, MUL_LAT);
        end
        total++;
        if (d !== 32'hFFFF_FFEB || r !== 5'd5) begin
            bad++;
            $display("FAIL mul_res: got rd=%0d data=%h want 5/ffffffeb", r, d);
        end
        total++;
        if (lo !== 1'b1) begin
            bad++;
            $display("FAIL mul_ready: got in_ready high early, want low");
        end
        total++;
        if (pw !== 1'b0 || pr !== 1'b1 || rd_data !== 32'hFFFF_FFEB) begin
            bad++;
            $display("FAIL mul_after: got we=%b rdy=%b data=%h want 0/1/ffffffeb",
                     pw, pr, rd_data);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  f[3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] a[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int lat;
        logic [31:0] d;
        logic [4:0] r;
        bit lo;
        logic pw, pr;
        for (int i = 0; i < 3; i++) begin
            issue(f[i], a[i], a[i], 5'(i + 10));
            wait_wb(lat, d, r, lo, pw, pr);
            total++;
            if (lat !== MUL_LAT || d !== e[i] || r !== 5'(i + 10)) begin
                bad++;
                $display("FAIL mulh_%0d: got lat=%0d rd=%0d data=%h want %0d/%0d/%h",
                         i, lat, r, d, MUL_LAT, i + 10, e[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] b[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] e[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat;
        logic [31:0] d;
        logic [4:0] r;
        bit lo;
        logic pw, pr;
        for (int i = 0; i < 4; i++) begin
            issue(f[i], a[i], b[i], 5'(i + 1));
            wait_wb(lat, d, r, lo, pw, pr);
            total++;
            if (lat !== DIV_LAT || d !== e[i] || r !== 5'(i + 1) || lo !== 1'b1) begin
                bad++;
                $display("FAIL div_%0d: got lat=%0d rd=%0d data=%h want %0d/%0d/%h",
                         i, lat, r, d, DIV_LAT, i + 1, e[i]);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  f[5] = '{3'b100, 3'b110, 3'b101, 3'b100, 3'b110};
        logic [31:0] a[5] = '{32'd5, 32'd5, 32'h8000_0000,
                              32'h8000_0000, 32'h8000_0000};
        logic [31:0] b[5] = '{32'd0, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e[5] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'd0};
        int lat;
        logic [31:0] d;
        logic [4:0] r;
        bit lo;
        logic pw, pr;
        for (int i = 0; i < 5; i++) begin
            issue(f[i], a[i], b[i], 5'd0);
            wait_wb(lat, d, r, lo, pw, pr);
            total++;
            if (lat !== DIV_LAT || d !== e[i] || r !== 5'd0) begin
                bad++;
                $display("FAIL divspec_%0d: got lat=%0d rd=%0d data=%h want %0d/0/%h",
                         i, lat, r, d, DIV_LAT, e[i]);
            end
        end
    endtask

    task automatic test_kill();
        int lat;
        logic [31:0] d;
        logic [4:0] r;
        bit lo;
        logic pw, pr;
        issue(3'b100, 32'd1000, 32'd3, 5'd7);
        for (int j = 1; j < 10; j++) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || rd_we !== 1'b0) begin
            bad++;
            $display("FAIL kill_idle: got rdy=%b busy=%b we=%b want 1/0/0",
                     in_ready, busy, rd_we);
        end
        issue(3'b101, 32'd100, 32'd7, 5'd9);
        wait_wb(lat, d, r, lo, pw, pr);
        total++;
        if (lat !== DIV_LAT || d !== 32'd14 || r !== 5'd9) begin
            bad++;
            $display("FAIL kill_next: got lat=%0d rd=%0d data=%h want %0d/9/0000000e",
                     lat, r, d, DIV_LAT);
        end
    endtask

    task automatic test_rst_mid();
        int seen = 0;
        issue(3'b101, 32'd500, 32'd3, 5'd12);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({rd, rd_data, rd_we, busy} !== 39'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid: got rd=%0d data=%h we=%b busy=%b rdy=%b want 0/0/0/0/1",
                     rd, rd_data, rd_we, busy, in_ready);
        end
        for (int j = 0; j < 40; j++) begin
            if (rd_we === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rst_stale: got %0d writebacks want 0", seen);
        end
    endtask

    task automatic test_kill_issue();
        int seen = 0;
        in_valid = 1'b1;
        kill     = 1'b1;
        funct3   = 3'b000;
        op_a     = 32'd3;
        op_b     = 32'd4;
        rd_in    = 5'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL kill_issue: got busy=%b rdy=%b want 0/1", busy, in_ready);
        end
        for (int j = 0; j < 40; j++) begin
            if (rd_we === 1'b1 || busy !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL kill_issue_wb: got %0d busy/we cycles want 0", seen);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        kill     = 1'b0;
        funct3   = 3'b000;
        op_a     = '0;
        op_b     = '0;
        rd_in    = '0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_special();
        test_kill();
        test_rst_mid();
        test_kill_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit in the cust-risc core.
- Sits between operand fetch and the register file.
- Consumes rs1/rs2 operand values read from the register file and produces a single writeback (rd, rd_data, rd_we) that feeds the register file write port directly.
- Multi-cycle, one operation in flight, valid/ready on the issue side.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  issue request valid.
- in_ready  output  1  unit can accept an issue; high only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  WIDTH  rs1 value.
- op_b  input  WIDTH  rs2 value.
- rd_in  input  5  destination register index.
- kill  input  1  pipeline flush; aborts the in-flight op.
- busy  output  1  high while an op is accepted and not yet written back.
- rd  output  5  writeback destination index (registered).
- rd_data  output  WIDTH  writeback value (registered).
- rd_we  output  1  writeback strobe, one-cycle pulse.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - rd=0, rd_data=0, rd_we=0, busy=0, in_ready=1 after the edge.
  - Overrides everything, including mid-operation; no writeback for the aborted op.
- States:
  - IDLE: in_ready=1. On in_valid && !kill, latch funct3, rd_in and operands, then go to CALC.
  - CALC: iterative loop, one bit per cycle, for exactly WIDTH cycles.
    - Multiply: shift-add on operand magnitudes, 2*WIDTH-bit product, sign fixed up at the end.
    - Divide: restoring division on magnitudes.
  - DONE: rd_we=1 for one cycle with rd/rd_data valid, then go to IDLE.
- Latency: issue accepted at edge N; CALC occupies cycles N+1..N+WIDTH; rd_we=1 in cycle N+WIDTH+1; in_ready=1 again from N+WIDTH+2.
- busy=1 in CALC and DONE.
- rd and rd_data hold their last value after the rd_we pulse.
- rd_we pulses even when rd=0; the register file discards writes to x0.
- Result selection:
  - MUL: low WIDTH bits of the product.
  - MULH: high bits, signed x signed.
  - MULHSU: high bits, signed op_a x unsigned op_b.
  - MULHU: high bits, unsigned x unsigned.
  - DIV/REM: truncate toward zero; remainder takes the sign of the dividend.
- Special cases (same fixed latency, no early exit):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give op_a.
  - Signed overflow (op_a = most-negative value, op_b = -1): DIV gives op_a; REM gives 0.
- kill:
  - In CALC: go to IDLE at the next edge, no rd_we.
  - In IDLE together with in_valid: the issue is not accepted.
  - In DONE: no effect; the write completes.
- Operand inputs are sampled only at the accept edge; later changes are ignored.

Optional Feature:
- MDU_FAST_MUL_EN:
  - Defined: MUL/MULH/MULHSU/MULHU compute a full 2*WIDTH-bit product in one cycle. Accept at N goes to DONE in cycle N+1 (rd_we in N+1, in_ready again at N+2). CALC is used only by divide ops.
  - Undefined: all ops use the iterative path with the latency above.
  - Results are identical either way.

Test Plan:
- Reset, then MUL op_a=7, op_b=0xFFFFFFFD, rd_in=5 accepted at edge N -> rd_we=1 only in cycle N+33, rd=5, rd_data=0xFFFFFFEB; in_ready=0 in cycles N+1..N+33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. With MDU_FAST_MUL_EN defined, each has rd_we at N+1.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIVU 0x80000000/0 -> 0xFFFFFFFF. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- kill pulsed in cycle N+10 of a DIV -> no rd_we, in_ready=1 from N+11. New issue at N+11 completes normally with rd_we in cycle N+44.
- rst asserted mid-CALC -> next cycle rd=0, rd_data=0, rd_we=0, busy=0, no stale writeback. Issue with in_valid=1 and kill=1 in IDLE -> not accepted, busy stays 0.
